eth_tx_mmio: RTL and testbench
==============================

Name: eth_tx_mmio

Overview:
Memory-mapped responder for the Ethernet transmit window at 0x10810000 (DATA) and 0x10810004 (STAT). The CPU bus addresses it through the system address decoder, which selects this window.
- Buffers CPU-written bytes in a FIFO and streams them to the Ethernet byte transmitter over a valid/ready handshake.
- Store-and-forward: bytes are released only once a complete frame is buffered, or when the FIFO is full.

Parameters:
BASE_ADDR, 32'h10810000, byte address of DATA; STAT is at BASE_ADDR+4
DEPTH, 16, FIFO entries (power of two, ≥2)
AW, 4, log2(DEPTH)

Ports:
clk  input  1  system clock; all state changes on rising edge
rst_n  input  1  asynchronous active-low reset
addr  input  32  CPU byte address
cs  input  1  window select from the address decoder
sig_w  input  1  CPU write strobe
sig_r  input  1  CPU read strobe
wdata  input  32  CPU write data
rdata  output  32  CPU read data (combinational)
tx_data  output  8  byte to transmitter
tx_last  output  1  byte is last of frame
tx_valid  output  1  tx_data/tx_last valid
tx_ready  input  1  transmitter accepts byte

Behaviour:
- Reset (async, rst_n=0): FIFO empty, wr/rd pointers=0, count=0, frames_pending=0, ovf=0. Outputs tx_valid=0, tx_data=0, tx_last=0, rdata=0.
- Decode:
  - hit_data = cs & (addr==BASE_ADDR).
  - hit_stat = cs & (addr==BASE_ADDR+4).
  - Other addresses are ignored: rdata=0.
- DATA write (hit_data & sig_w):
  - push entry {wdata[8]=last, wdata[7:0]=byte}.
  - Accepted only if the FIFO is not full pre-edge; otherwise the entry is dropped and ovf is set to 1 (sticky).
- DATA read: rdata=0.
- STAT read (hit_stat & sig_r), combinational:
  - rdata = {16'b0, count padded to 8 bits [15:8], 4'b0, ovf[3], tx_valid[2], full[1], empty[0]}.
  - ovf clears at the edge ending the read cycle. If an overflow occurs in the same cycle, ovf stays 1.
- STAT write (hit_stat & sig_w) with wdata[0]=1 is a flush:
  - next edge: pointers, count and frames_pending=0.
  - Overrides any same-cycle push or pop; no pop handshake is counted.
  - ovf is unaffected.
- Pop: tx_valid & tx_ready at an edge advances rd pointer and decrements count.
- tx_valid = !empty & (frames_pending!=0 | full).
- tx_data/tx_last come from the FIFO head (show-ahead); they are stable while tx_valid=1 & tx_ready=0.
- Simultaneous push and pop:
  - count unchanged; both pointers advance.
  - Push acceptance uses pre-edge full, so a push on full is dropped even if a pop occurs that cycle.
- frames_pending (width AW+1):
  - +1 on accepted push with last=1.
  - -1 on pop with last=1.
  - Unchanged when both occur in the same cycle.
  - Never underflows, because a pop with last=1 implies a prior counted push.
- Full-release: when full with frames_pending=0, bytes drain as a partial frame; tx_last follows the stored flag.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH; full = (count==DEPTH).
- Latency: a byte written with last=1 into an empty FIFO gives tx_valid=1 in the cycle after the write edge.
- No back-pressure to the CPU; software polls STAT.full.

Decomposition:
- Shared package `eth_tx_pkg`:
  - DATA_OFS=0, STAT_OFS=4.
  - STAT bit positions (EMPTY=0, FULL=1, VALID=2, OVF=3, COUNT_LSB=8).
  - LAST_BIT=8.
- One sub-module: `sync_fifo` (DEPTH×9 bits; push/pop/flush, count, full/empty, show-ahead head).
- Decode, frames_pending, ovf and read mux live in the top.

Test Plan:
- Reset: hold rst_n=0 mid-stream with 3 bytes queued → tx_valid=0, STAT read returns 0x00000001; after release, writes work normally.
- Store-and-forward: write DATA 0x011, 0x022, 0x133 (last on the third) with tx_ready=1 → tx_valid=0 until the third write, then bytes 11, 22, 33 on consecutive cycles, tx_last=1 only on 33; STAT then 0x00000001.
- Overflow: 17 DATA writes without last, tx_ready=0 → STAT=0x0000100E (count 16, ovf, valid, full); a second STAT read returns 0x00001006.
- Back-pressure: frame {AA,BB(last)} with tx_ready toggling 0/1 → tx_data holds AA while ready=0; exactly 2 handshakes; frames_pending returns to 0.
- Simultaneous push/pop: full FIFO with one frame, push plus pop in the same cycle → push dropped, count=15, ovf=1; with count=8, push plus pop leaves count=8.
- Flush: write STAT 0x1 while a push and a pop are active → next cycle empty=1, tx_valid=0, count=0, ovf unchanged.

Source files
------------

// File: rtl/eth_tx_pkg.sv
// Shared constants for the Ethernet transmit MMIO window: register offsets,
// STAT bit positions and the position of the end-of-frame flag in DATA writes.
package eth_tx_pkg;

  localparam logic [31:0] DATA_OFS = 32'd0;
  localparam logic [31:0] STAT_OFS = 32'd4;

  localparam int STAT_EMPTY     = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_VALID     = 2;
  localparam int STAT_OVF       = 3;
  localparam int STAT_COUNT_LSB = 8;

  localparam int LAST_BIT = 8;

  // Assembles the STAT read word from its individual fields.
  function automatic logic [31:0] packStatus(input logic [7:0] count,
                                             input logic ovf,
                                             input logic valid,
                                             input logic full,
                                             input logic empty);
    logic [31:0] word;
    word = '0;
    word[STAT_COUNT_LSB +: 8] = count;
    word[STAT_OVF]            = ovf;
    word[STAT_VALID]          = valid;
    word[STAT_FULL]           = full;
    word[STAT_EMPTY]          = empty;
    return word;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead head output, occupancy count and a
// synchronous flush that takes priority over any push or pop in the same cycle.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic [AW:0]      count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW:0]      count_q, count_d;
  logic             doPush, doPop;

  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_q];

  assign doPush = push_i & ~full_o & ~flush_i;
  assign doPop  = pop_i & ~empty_o & ~flush_i;

  // Next pointers and count; flush wins, otherwise push and pop act independently.
  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (flush_i) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      if (doPush) wr_d = wr_q + PTR_ONE;
      if (doPop)  rd_d = rd_q + PTR_ONE;
      if (doPush && !doPop)      count_d = count_q + CNT_ONE;
      else if (doPop && !doPush) count_d = count_q - CNT_ONE;
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // Storage array; contents are only meaningful between rd and wr pointers, so no reset.
  always_ff @(posedge clk) begin
    if (doPush) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/eth_tx_mmio.sv
// CPU-facing transmit window: DATA writes queue bytes, STAT reports/flushes,
// and bytes are released to the transmitter store-and-forward (whole frame or full FIFO).
module eth_tx_mmio
  import eth_tx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h1081_0000,
  parameter int          DEPTH     = 16,
  parameter int          AW        = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic        cs,
  input  logic        sig_w,
  input  logic        sig_r,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [7:0]  tx_data,
  output logic        tx_last,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam logic [AW:0] FP_ONE = {{AW{1'b0}}, 1'b1};

  logic        hitData, hitStat;
  logic        dataWr, statRd, flush;
  logic        pushOk, popFire;
  logic [8:0]  head;
  logic [AW:0] count;
  logic        full, empty;
  logic [AW:0] framesPending_q, framesPending_d;
  logic        ovf_q, ovf_d;
  logic        unusedWdata;

  assign hitData = cs & (addr == BASE_ADDR + DATA_OFS);
  assign hitStat = cs & (addr == BASE_ADDR + STAT_OFS);
  assign dataWr  = hitData & sig_w;
  assign statRd  = hitStat & sig_r;
  assign flush   = hitStat & sig_w & wdata[0];
  assign pushOk  = dataWr & ~full;
  assign popFire = tx_valid & tx_ready;

  assign unusedWdata = ^wdata[31:LAST_BIT+1];

  sync_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .WIDTH (9)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (dataWr),
    .pop_i   (popFire),
    .flush_i (flush),
    .din_i   (wdata[LAST_BIT:0]),
    .dout_o  (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  // Release gate plus head presentation; the head is forced to zero when nothing is stored.
  always_comb begin
    tx_valid = ~empty & ((framesPending_q != '0) | full);
    tx_data  = empty ? 8'h00 : head[7:0];
    tx_last  = empty ? 1'b0 : head[LAST_BIT];
  end

  // Complete-frame tally and sticky overflow flag (cleared by a STAT read unless re-set).
  always_comb begin
    framesPending_d = framesPending_q;
    ovf_d           = ovf_q;
    if (flush) begin
      framesPending_d = '0;
    end else begin
      if ((pushOk && wdata[LAST_BIT]) && !(popFire && head[LAST_BIT]))
        framesPending_d = framesPending_q + FP_ONE;
      else if (!(pushOk && wdata[LAST_BIT]) && (popFire && head[LAST_BIT]))
        framesPending_d = framesPending_q - FP_ONE;
    end
    if (dataWr && full) ovf_d = 1'b1;
    else if (statRd)    ovf_d = 1'b0;
  end

  // Frame tally and overflow registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      framesPending_q <= '0;
      ovf_q           <= 1'b0;
    end else begin
      framesPending_q <= framesPending_d;
      ovf_q           <= ovf_d;
    end
  end

  // Read mux: only a STAT read returns data, everything else reads as zero.
  always_comb begin
    rdata = '0;
    if (statRd) rdata = packStatus(8'(count), ovf_q, tx_valid, full, empty);
  end

endmodule

// File: tb/tb_eth_tx_mmio.sv
// Directed testbench for eth_tx_mmio with hand-computed expected values.
module tb_eth_tx_mmio;

  localparam logic [31:0] BASE = 32'h1081_0000;
  localparam logic [31:0] STAT = 32'h1081_0004;

  logic        clk;
  logic        rst_n;
  logic [31:0] addr;
  logic        cs;
  logic        sig_w;
  logic        sig_r;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [7:0]  tx_data;
  logic        tx_last;
  logic        tx_valid;
  logic        tx_ready;

  int          vectors;
  int          miscompares;
  logic [31:0] lastRdata;
  int          handshakes;

  logic       bpReady [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic       bpValid [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [7:0] bpData  [5] = '{8'hAA, 8'hAA, 8'hBB, 8'hBB, 8'h00};
  logic       bpLast  [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  eth_tx_mmio dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .addr     (addr),
    .cs       (cs),
    .sig_w    (sig_w),
    .sig_r    (sig_r),
    .wdata    (wdata),
    .rdata    (rdata),
    .tx_data  (tx_data),
    .tx_last  (tx_last),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

  // 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every vector and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Checks valid, last and data together as one packed word.
  task automatic checkTx(input string tag, input logic v, input logic [7:0] d,
                         input logic l);
    checkOutput(tag, {22'b0, tx_valid, tx_last, tx_data}, {22'b0, v, l, d});
  endtask

  // One bus cycle, entered and left just after a falling edge; rdata is captured mid-cycle.
  task automatic applyStimulus(input logic w, input logic r, input logic [31:0] a,
                               input logic [31:0] d);
    cs    = 1'b1;
    addr  = a;
    sig_w = w;
    sig_r = r;
    wdata = d;
    #1 lastRdata = rdata;
    @(posedge clk);
    @(negedge clk);
    cs    = 1'b0;
    addr  = '0;
    sig_w = 1'b0;
    sig_r = 1'b0;
    wdata = '0;
  endtask

  task automatic writeData(input logic [31:0] d);
    applyStimulus(1'b1, 1'b0, BASE, d);
  endtask

  task automatic readStat();
    applyStimulus(1'b0, 1'b1, STAT, 32'h0);
  endtask

  task automatic flushFifo();
    applyStimulus(1'b1, 1'b0, STAT, 32'h1);
  endtask

  task automatic idleCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    handshakes  = 0;
    rst_n    = 1'b0;
    cs       = 1'b0;
    addr     = '0;
    sig_w    = 1'b0;
    sig_r    = 1'b0;
    wdata    = '0;
    tx_ready = 1'b0;

    // Reset state
    #1;
    checkTx("rst_tx", 1'b0, 8'h00, 1'b0);
    checkOutput("rst_rdata_idle", rdata, 32'h0);
    @(negedge clk);
    rst_n    = 1'b1;
    tx_ready = 1'b1;
    idleCycle();

    // Decode: DATA reads, other addresses and deselected accesses
    applyStimulus(1'b0, 1'b1, BASE, 32'h0);
    checkOutput("data_read", lastRdata, 32'h0);
    applyStimulus(1'b1, 1'b0, BASE + 32'h8, 32'h155);
    readStat();
    checkOutput("bad_addr_no_push", lastRdata, 32'h1);
    addr  = STAT;
    sig_r = 1'b1;
    #1 checkOutput("nocs_read", rdata, 32'h0);
    sig_r = 1'b0;
    addr  = '0;

    // Store-and-forward
    writeData(32'h011);
    checkOutput("sf_w1_valid", {31'b0, tx_valid}, 32'h0);
    writeData(32'h022);
    checkOutput("sf_w2_valid", {31'b0, tx_valid}, 32'h0);
    writeData(32'h133);
    checkTx("sf_b0", 1'b1, 8'h11, 1'b0);
    idleCycle();
    checkTx("sf_b1", 1'b1, 8'h22, 1'b0);
    idleCycle();
    checkTx("sf_b2", 1'b1, 8'h33, 1'b1);
    idleCycle();
    checkOutput("sf_done_valid", {31'b0, tx_valid}, 32'h0);
    readStat();
    checkOutput("sf_stat", lastRdata, 32'h1);

    // Overflow: 17 writes into 16 entries, no frame end
    tx_ready = 1'b0;
    for (int i = 0; i < 17; i++) writeData(32'h40 + i);
    checkTx("ovf_head", 1'b1, 8'h40, 1'b0);
    readStat();
    checkOutput("ovf_stat1", lastRdata, 32'h0000_100E);
    readStat();
    checkOutput("ovf_stat2", lastRdata, 32'h0000_1006);
    flushFifo();
    readStat();
    checkOutput("flush1_stat", lastRdata, 32'h1);

    // Back-pressure on a two-byte frame
    writeData(32'h0AA);
    writeData(32'h1BB);
    for (int c = 0; c < 5; c++) begin
      tx_ready = bpReady[c];
      #1;
      if (bpValid[c]) checkTx($sformatf("bp_cyc%0d", c), 1'b1, bpData[c], bpLast[c]);
      else checkOutput($sformatf("bp_cyc%0d_valid", c), {31'b0, tx_valid}, 32'h0);
      if (tx_valid && tx_ready) handshakes++;
      idleCycle();
    end
    tx_ready = 1'b0;
    checkOutput("bp_handshakes", handshakes, 32'd2);
    writeData(32'h0CC);
    checkOutput("bp_fp_zero", {31'b0, tx_valid}, 32'h0);
    flushFifo();

    // Simultaneous push and pop on a full FIFO holding one frame
    for (int i = 0; i < 15; i++) writeData(32'h60 + i);
    writeData(32'h16F);
    checkTx("full_head", 1'b1, 8'h60, 1'b0);
    tx_ready = 1'b1;
    writeData(32'h070);
    tx_ready = 1'b0;
    readStat();
    checkOutput("pp_full_stat", lastRdata, 32'h0000_0F0C);
    checkTx("pp_full_head", 1'b1, 8'h61, 1'b0);
    flushFifo();

    // Simultaneous push and pop at count 8
    for (int i = 0; i < 7; i++) writeData(32'h80 + i);
    writeData(32'h187);
    tx_ready = 1'b1;
    writeData(32'h088);
    tx_ready = 1'b0;
    readStat();
    checkOutput("pp8_stat", lastRdata, 32'h0000_0804);
    checkTx("pp8_head", 1'b1, 8'h81, 1'b0);

    // Flush during an active pop, with ovf set beforehand
    for (int i = 0; i < 8; i++) writeData(32'h90 + i);
    writeData(32'h0A0);
    tx_ready = 1'b1;
    flushFifo();
    tx_ready = 1'b0;
    checkOutput("flush_valid", {31'b0, tx_valid}, 32'h0);
    readStat();
    checkOutput("flush_stat_ovf", lastRdata, 32'h9);
    readStat();
    checkOutput("flush_stat_clr", lastRdata, 32'h1);
    writeData(32'h0DD);
    checkOutput("flush_fp_zero", {31'b0, tx_valid}, 32'h0);

    // Reset asserted mid-stream with 3 bytes queued
    writeData(32'h0DE);
    writeData(32'h1DF);
    checkTx("prerst_head", 1'b1, 8'hDD, 1'b0);
    rst_n = 1'b0;
    #1 checkOutput("midrst_valid", {31'b0, tx_valid}, 32'h0);
    cs    = 1'b1;
    addr  = STAT;
    sig_r = 1'b1;
    #1 checkOutput("midrst_stat", rdata, 32'h1);
    cs    = 1'b0;
    addr  = '0;
    sig_r = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idleCycle();
    writeData(32'h155);
    checkTx("postrst_frame", 1'b1, 8'h55, 1'b1);
    tx_ready = 1'b1;
    idleCycle();
    tx_ready = 1'b0;
    checkOutput("postrst_drained", {31'b0, tx_valid}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
